// File: rtl/spi_arbiter_seq_pkg.sv
// Shared definitions for the SPI arbiter: FSM encoding and the master's control-word layout.
package spi_arbiter_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DESEL = 3'd4
    } state_t;

    localparam int          SPI_CSX_BIT    = 8;
    localparam int          SPI_BUSY_BIT   = 15;
    localparam logic [15:0] SPI_DESEL_WORD = 16'h0100;

endpackage

// File: rtl/spi_arbiter_seq_rr_arbiter.sv
// Round-robin pick: lowest requester at or above i_ptr, wrapping to the lowest overall.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_pick_src;

    // NOTE: every variable gets a value on every pass through always_comb, so no latch is inferred.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(i_ptr));
        end
        w_masked   = i_req & w_mask;
        w_pick_src = (|w_masked) ? w_masked : i_req;
        o_grant    = w_pick_src & (~w_pick_src + {{(N-1){1'b0}}, 1'b1});
    end

endmodule

// File: rtl/spi_arbiter_seq.sv
// Shares one SPI master between N requesters: round-robin grant per transaction,
// byte streaming through the master's load/in/out port, and CSX framing.
module spi_arbiter_seq
    import spi_arbiter_seq_pkg::*;
#(
    parameter int N         = 2,
    parameter int DESEL_CYC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   rsp_valid,
    output logic [7:0]     rsp_data,
    output logic [N-1:0]   grant,
    output logic           spi_load,
    output logic [15:0]    spi_in,
    input  logic [15:0]    spi_out
);

    localparam int PTR_W = (N > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(DESEL_CYC + 1);

    state_t           r_state;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [N-1:0]     r_grant;
    logic [N-1:0]     r_req_ready;
    logic [N-1:0]     r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic             r_spi_load;
    logic [15:0]      r_spi_in;
    logic             r_last_q;
    logic [CNT_W-1:0] r_gap_cnt;

    logic [N-1:0]     w_arb_grant;
    logic             w_gnt_valid;
    logic             w_gnt_last;
    logic [7:0]       w_gnt_byte;
    logic [PTR_W-1:0] w_next_ptr;
    logic             w_spi_out_unused;

    rr_arbiter #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant)
    );

    assign w_gnt_valid      = |(req_valid & r_grant);
    assign w_gnt_last       = |(req_last & r_grant);
    assign w_spi_out_unused = ^spi_out[SPI_BUSY_BIT-1:SPI_CSX_BIT];

    always_comb begin
        w_gnt_byte = '0;
        w_next_ptr = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_gnt_byte = w_gnt_byte | req_data[i*8 +: 8];
                w_next_ptr = PTR_W'((i + 1) % N);
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values; no memories here, all state is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_spi_load  <= 1'b0;
            r_spi_in    <= SPI_DESEL_WORD;
            r_last_q    <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            r_spi_load  <= 1'b0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant <= w_arb_grant;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_gnt_valid) begin
                        r_spi_load  <= 1'b1;
                        r_req_ready <= r_grant;
                        r_spi_in    <= {7'd0, 1'b0, w_gnt_byte};
                        r_last_q    <= w_gnt_last;
                        r_state     <= ST_ARM;
                    end
                end
                // The master raises busy one cycle after load; skip that cycle before polling.
                ST_ARM: r_state <= ST_BUSY;
                ST_BUSY: begin
                    if (!spi_out[SPI_BUSY_BIT]) begin
                        r_rsp_data  <= spi_out[7:0];
                        r_rsp_valid <= r_grant;
                        r_gap_cnt   <= '0;
                        r_state     <= r_last_q ? ST_DESEL : ST_LOAD;
                    end
                end
                ST_DESEL: begin
                    if (r_gap_cnt == '0) begin
                        r_spi_load <= 1'b1;
                        r_spi_in   <= SPI_DESEL_WORD;
                        r_grant    <= '0;
                        r_rr_ptr   <= w_next_ptr;
                    end
                    if (r_gap_cnt == CNT_W'(DESEL_CYC)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign grant     = r_grant;
    assign spi_load  = r_spi_load;
    assign spi_in    = r_spi_in;

endmodule
